fdiv_issue: RTL and testbench
=============================

# fdiv_issue

Sequential issue/retire stage wrapped around the combinational single-precision divider `fdiv`. It does four things:
- accepts operand pairs over a valid/ready handshake and buffers them in a 2-entry FIFO;
- short-circuits IEEE special cases without using the divider;
- for normal operands, drives the divider and waits a fixed multicycle-path budget before capturing its result;
- presents one result at a time on a valid/ready output.

## Interface
- `exp`, 8, exponent field width
- `frac`, 23, fraction field width
- `width`, exp+frac+1, word width
- `div_lat`, 2, cycles allowed for the combinational divider path (≥1)
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  reset, synchronous, active-high
- `in_valid`  in  1  operand pair offered
- `in_ready`  out  1  FIFO not full
- `in_a`  in  width  dividend
- `in_b`  in  width  divisor
- `in_round`  in  1  round_mode for this operation (1 nearest, 0 truncate)
- `div_a`  out  width  operand A to divider
- `div_b`  out  width  operand B to divider
- `div_round`  out  1  round_mode to divider
- `div_r`  in  width  divider result
- `div_flags`  in  4  divider flags
- `out_valid`  out  1  result available
- `out_ready`  in  1  consumer accepts
- `out_r`  out  width  result
- `out_flags`  out  4  {invalid, divzero, overflow, underflow}

## Operation
- FIFO:
  - 2 entries of {a, b, round}.
  - Push on `in_valid && in_ready`; `in_ready = !full`.
  - No pass-through when full: a pop in the same cycle does not free a slot for a push.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - If the FIFO is non-empty, pop the head into the operand registers, classify both operands, clear `cnt`, and go to BUSY.
  - If the FIFO is empty, stay in IDLE.
- BUSY:
  - `div_a`/`div_b`/`div_round` are driven from the operand registers.
  - Special case: load the special result into `out_r`/`out_flags` and go to DONE.
  - Otherwise, when `cnt == div_lat-1`, capture `div_r`/`div_flags` and go to DONE; if not, increment `cnt`.
- DONE: `out_valid=1`. On `out_ready`, go to IDLE. There is no direct DONE→BUSY transition.
- Classification uses the exponent/fraction fields. Special results are checked in this priority order:
  1. Either operand NaN → 0x7FC00000 (quiet NaN, sign 0), invalid=1.
  2. 0/0 or inf/inf → 0x7FC00000, invalid=1.
  3. Finite nonzero / 0 → signed inf, divzero=1.
  4. inf / finite → signed inf, no flags.
  5. 0 / nonzero, or finite / inf → signed zero, no flags.
- Sign of all non-NaN special results = `sign_a ^ sign_b`.
- Denormal operands are not special; they go to the divider.
- Reset:
  - Every output register is 0: `out_valid`, `out_r`, `out_flags`, `div_a`, `div_b`, `div_round`.
  - FIFO empty, so `in_ready=1` from the first cycle after reset.
  - State IDLE.
  - Reset mid-operation discards the FIFO contents and any in-flight operation, with no output.

## Timing
- Edge 0 is the edge at which an accept is sampled, with the FIFO empty and the FSM in IDLE.
- Normal operation: `out_valid` high after edge `div_lat+1` (3 with the default).
- Special case: `out_valid` high after edge 2.
- Throughput: one result per `div_lat+2` cycles (normal) or 3 cycles (special) when `out_ready` is held high.
- `out_r`/`out_flags` are stable while `out_valid && !out_ready`.
- `div_*` are stable from entry into BUSY until the next IDLE pop.

## Configuration
- `FDIV_BYPASS_EN` defined: special-case detection and bypass as above.
- Not defined: no classification. Every operation waits the full `div_lat` budget and returns `div_r`/`div_flags` unchanged. The special-case result mux is absent.

## Test plan
- 6.0/2.0 (0x40C00000 / 0x40000000), bench divider model, `div_lat=2` → `out_r=0x40400000`, flags 0000, `out_valid` after edge 3.
- 1.0/0 (0x3F800000 / 0x00000000) → `out_r=0x7F800000`, flags 0100, `out_valid` after edge 2. Without `FDIV_BYPASS_EN`: divider output instead, after edge 3.
- 0/0 → 0x7FC00000 with flags 1000. -inf/2.0 → 0xFF800000 with flags 0000.
- `out_ready` held 0; push 4 ops back-to-back → 3 accepted (1 in operand registers, 2 in FIFO), `in_ready=0` on the 4th. Release → results in push order.
- Assert `rst` one cycle while BUSY with 2 entries queued → next cycle: `out_valid=0`, `in_ready=1`, outputs 0, and no stale results afterwards.
- Push while full with same-cycle `out_ready=1` → push refused. FIFO count changes only via pop.

Source files
------------

// File: rtl/fdiv_issue.sv
// Issue/retire stage around the combinational fdiv: 2-entry operand FIFO, multicycle capture, one result at a time.
// Latency: div_lat+1 edges from accept (2 for IEEE special cases); in_ready = FIFO not full; output holds until out_ready.
// `FDIV_BYPASS_EN enables special-case classification and bypass; undefined, every op goes through the divider.
module fdiv_issue #(
  parameter int exp     = 8,
  parameter int frac    = 23,
  parameter int width   = exp + frac + 1,
  parameter int div_lat = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [width-1:0] in_a,
  input  logic [width-1:0] in_b,
  input  logic             in_round,
  output logic [width-1:0] div_a,
  output logic [width-1:0] div_b,
  output logic             div_round,
  input  logic [width-1:0] div_r,
  input  logic [3:0]       div_flags,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [width-1:0] out_r,
  output logic [3:0]       out_flags
);

  localparam int ent_w = 2 * (exp + frac + 1) + 1;
  localparam int cnt_w = (div_lat > 1) ? $clog2(div_lat) : 1;
  localparam logic [cnt_w-1:0] cnt_last = cnt_w'(div_lat - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q, state_d;
  logic [cnt_w-1:0] cnt_q, cnt_d;
  logic [ent_w-1:0] mem_q [2];
  logic [ent_w-1:0] mem_d [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;
  logic [width-1:0] div_a_q, div_a_d, div_b_q, div_b_d;
  logic             div_round_q, div_round_d;
  logic [width-1:0] out_r_q, out_r_d;
  logic [3:0]       out_flags_q, out_flags_d;

  logic [ent_w-1:0] head;
  logic [width-1:0] head_a, head_b;
  logic             head_round;
  logic             push, pop;

  assign head       = mem_q[rd_ptr_q];
  assign head_a     = head[ent_w-1 -: width];
  assign head_b     = head[width:1];
  assign head_round = head[0];

  // in_ready looks only at the current fill level, so a same-cycle pop never makes room for a push
  assign in_ready = (count_q != 2'd2);
  assign push     = in_valid && in_ready;
  assign pop      = (state_q == IDLE) && (count_q != 2'd0);

`ifdef FDIV_BYPASS_EN
  logic             spec_q, spec_d;
  logic [width-1:0] spec_r_q, spec_r_d;
  logic [3:0]       spec_flags_q, spec_flags_d;
  logic             cls_spec;
  logic [width-1:0] cls_r;
  logic [3:0]       cls_flags;
  logic [exp-1:0]   ea, eb;
  logic [frac-1:0]  fa, fb;
  logic             a_nan, a_inf, a_zero, b_nan, b_inf, b_zero, sgn;

  assign ea     = head_a[width-2 -: exp];
  assign eb     = head_b[width-2 -: exp];
  assign fa     = head_a[frac-1:0];
  assign fb     = head_b[frac-1:0];
  assign a_nan  = (&ea) && (|fa);
  assign a_inf  = (&ea) && !(|fa);
  assign a_zero = !(|ea) && !(|fa);
  assign b_nan  = (&eb) && (|fb);
  assign b_inf  = (&eb) && !(|fb);
  assign b_zero = !(|eb) && !(|fb);
  assign sgn    = head_a[width-1] ^ head_b[width-1];

  always_comb begin
    cls_spec  = 1'b1;
    cls_r     = '0;
    cls_flags = 4'b0000;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      cls_r     = {1'b0, {exp{1'b1}}, 1'b1, {(frac-1){1'b0}}};
      cls_flags = 4'b1000;
    end else if (b_zero && !a_inf) begin
      cls_r     = {sgn, {exp{1'b1}}, {frac{1'b0}}};
      cls_flags = 4'b0100;
    end else if (a_inf) begin
      cls_r = {sgn, {exp{1'b1}}, {frac{1'b0}}};
    end else if (a_zero || b_inf) begin
      cls_r = {sgn, {(width-1){1'b0}}};
    end else begin
      cls_spec = 1'b0;
    end
  end
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_d[0]    = mem_q[0];
    mem_d[1]    = mem_q[1];
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q + {1'b0, push} - {1'b0, pop};
    div_a_d     = div_a_q;
    div_b_d     = div_b_q;
    div_round_d = div_round_q;
    out_r_d     = out_r_q;
    out_flags_d = out_flags_q;
`ifdef FDIV_BYPASS_EN
    spec_d       = spec_q;
    spec_r_d     = spec_r_q;
    spec_flags_d = spec_flags_q;
`endif

    if (push) begin
      mem_d[wr_ptr_q] = {in_a, in_b, in_round};
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end

    case (state_q)
      IDLE: begin
        if (pop) begin
          div_a_d     = head_a;
          div_b_d     = head_b;
          div_round_d = head_round;
          cnt_d       = '0;
          state_d     = BUSY;
`ifdef FDIV_BYPASS_EN
          spec_d       = cls_spec;
          spec_r_d     = cls_r;
          spec_flags_d = cls_flags;
`endif
        end
      end
      BUSY: begin
`ifdef FDIV_BYPASS_EN
        if (spec_q) begin
          out_r_d     = spec_r_q;
          out_flags_d = spec_flags_q;
          state_d     = DONE;
        end else
`endif
        if (cnt_q == cnt_last) begin
          out_r_d     = div_r;
          out_flags_d = div_flags;
          state_d     = DONE;
        end else begin
          cnt_d = cnt_q + cnt_w'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mem_q[0]    <= '0;
      mem_q[1]    <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      count_q     <= 2'd0;
      div_a_q     <= '0;
      div_b_q     <= '0;
      div_round_q <= 1'b0;
      out_r_q     <= '0;
      out_flags_q <= 4'b0000;
`ifdef FDIV_BYPASS_EN
      spec_q       <= 1'b0;
      spec_r_q     <= '0;
      spec_flags_q <= 4'b0000;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_q[0]    <= mem_d[0];
      mem_q[1]    <= mem_d[1];
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      div_a_q     <= div_a_d;
      div_b_q     <= div_b_d;
      div_round_q <= div_round_d;
      out_r_q     <= out_r_d;
      out_flags_q <= out_flags_d;
`ifdef FDIV_BYPASS_EN
      spec_q       <= spec_d;
      spec_r_q     <= spec_r_d;
      spec_flags_q <= spec_flags_d;
`endif
    end
  end

  assign out_valid = (state_q == DONE);
  assign out_r     = out_r_q;
  assign out_flags = out_flags_q;
  assign div_a     = div_a_q;
  assign div_b     = div_b_q;
  assign div_round = div_round_q;

endmodule

// File: tb/tb_fdiv_issue.sv
// Bench for fdiv_issue: behavioural divider stand-in, scoreboard queue of expected {r, flags}, latency and backpressure checks.
module tb_fdiv_issue;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a, in_b;
  logic        in_round;
  logic [31:0] div_a, div_b, div_r;
  logic        div_round;
  logic [3:0]  div_flags;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_r;
  logic [3:0]  out_flags;

  int          checks = 0;
  int          fails  = 0;
  logic [35:0] q[$];
  logic [35:0] mon_e;

  always #5 clk = ~clk;

  fdiv_issue dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_round  (in_round),
    .div_a     (div_a),
    .div_b     (div_b),
    .div_round (div_round),
    .div_r     (div_r),
    .div_flags (div_flags),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_r     (out_r),
    .out_flags (out_flags)
  );

  // Stand-in divider: a few exact quotients, otherwise an arbitrary but deterministic scramble.
  function automatic logic [35:0] model_div(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      64'h40C00000_40000000: return {32'h40400000, 4'b0000};
      64'h3F800000_40000000: return {32'h3F000000, 4'b0000};
      default:               return {a ^ {b[15:0], b[31:16]}, a[3:0] ^ b[7:4] ^ 4'b0010};
    endcase
  endfunction

  assign {div_r, div_flags} = model_div(div_a, div_b);

  function automatic logic is_spec(input logic [31:0] a, input logic [31:0] b);
`ifdef FDIV_BYPASS_EN
    return (a[30:23] == 8'hFF) || (b[30:23] == 8'hFF) || (a[30:0] == 31'd0) || (b[30:0] == 31'd0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [35:0] ref_result(input logic [31:0] a, input logic [31:0] b);
    logic an, ai, az, bn, bi, bz, s;
    an = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    ai = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    az = (a[30:0] == 31'd0);
    bn = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    bi = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    bz = (b[30:0] == 31'd0);
    s  = a[31] ^ b[31];
    if (is_spec(a, b)) begin
      if (an || bn)                 return {32'h7FC00000, 4'b1000};
      if ((az && bz) || (ai && bi)) return {32'h7FC00000, 4'b1000};
      if (ai)                       return {s, 31'h7F800000, 4'b0000};
      if (bz)                       return {s, 31'h7F800000, 4'b0100};
      return {s, 31'd0, 4'b0000};
    end
    return model_div(a, b);
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_out", {63'd0, out_valid}, 64'd0);
      end else begin
        mon_e = q.pop_front();
        chk("result", {28'd0, out_r, out_flags}, {28'd0, mon_e});
      end
    end
  end

  // Starts #1 after a posedge with the FSM idle and the FIFO empty.
  task automatic run_one(input string tag, input logic [31:0] a, input logic [31:0] b, input logic rnd);
    int lat;
    int want_lat;
    want_lat = is_spec(a, b) ? 2 : 3;
    q.push_back(ref_result(a, b));
    in_a = a; in_b = b; in_round = rnd; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = -1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = n;
        break;
      end
    end
    chk({tag, "_lat"}, 64'(lat), 64'(want_lat));
    if (lat >= 0) begin
      chk({tag, "_div_a"}, {32'd0, div_a}, {32'd0, a});
      chk({tag, "_div_b"}, {32'd0, div_b}, {32'd0, b});
      chk({tag, "_div_round"}, {63'd0, div_round}, {63'd0, rnd});
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(posedge clk); #1;
    chk({tag, "_drained"}, 64'(q.size()), 64'd0);
    q.delete();
  endtask

  logic [31:0] bp_a [4];
  logic [31:0] bp_b [4];
  int          acc;
  logic        rdy3;

  initial begin
    #400000;
    $display("FAIL global_timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_round = 1'b0; out_ready = 1'b0;
    bp_a[0] = 32'h40C00000; bp_b[0] = 32'h40000000;
    bp_a[1] = 32'h3F800000; bp_b[1] = 32'h40000000;
    bp_a[2] = 32'h40000000; bp_b[2] = 32'h3FC00000;
    bp_a[3] = 32'h41000000; bp_b[3] = 32'h40400000;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_out_r", {32'd0, out_r}, 64'd0);
    chk("rst_out_flags", {60'd0, out_flags}, 64'd0);
    chk("rst_div_ab", {div_a, div_b}, 64'd0);
    chk("rst_div_round", {63'd0, div_round}, 64'd0);
    @(posedge clk); #1;

    run_one("six_by_two",  32'h40C00000, 32'h40000000, 1'b1);
    run_one("one_by_zero", 32'h3F800000, 32'h00000000, 1'b1);
    run_one("zero_zero",   32'h00000000, 32'h00000000, 1'b1);
    run_one("ninf_by_two", 32'hFF800000, 32'h40000000, 1'b0);
    run_one("nan_by_one",  32'h7FC00001, 32'h3F800000, 1'b1);
    run_one("inf_inf",     32'h7F800000, 32'hFF800000, 1'b1);
    run_one("m3_by_zero",  32'hC0400000, 32'h00000000, 1'b1);
    run_one("two_by_ninf", 32'h40000000, 32'hFF800000, 1'b1);
    run_one("inf_by_zero", 32'h7F800000, 32'h00000000, 1'b0);
    run_one("zero_by_5",   32'h00000000, 32'h40A00000, 1'b1);
    run_one("denorm",      32'h00000001, 32'h3F800000, 1'b1);
    run_one("one_by_two",  32'h3F800000, 32'h40000000, 1'b0);

    // Backpressure: out_ready low, four back-to-back offers.
    acc = 0; rdy3 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_a = bp_a[i]; in_b = bp_b[i]; in_round = 1'b1; in_valid = 1'b1;
      @(negedge clk);
      if (i == 3) rdy3 = in_ready;
      if (in_ready) begin
        acc++;
        q.push_back(ref_result(bp_a[i], bp_b[i]));
      end
      @(posedge clk); #1;
    end
    chk("bp_accepted", 64'(acc), 64'd3);
    chk("bp_in_ready_4th", {63'd0, rdy3}, 64'd0);
    out_ready = 1'b1;
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("no_passthru", {63'd0, in_ready}, 64'd0);
    @(posedge clk);
    @(negedge clk);
    chk("ready_after_pop", {63'd0, in_ready}, 64'd1);
    if (in_ready) q.push_back(ref_result(bp_a[3], bp_b[3]));
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int n = 0; n < 60 && q.size() != 0; n++) @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
    chk("bp_drain", 64'(q.size()), 64'd0);
    out_ready = 1'b0;
    q.delete();
    @(posedge clk); #1;

    // Reset while busy with two entries queued.
    for (int i = 0; i < 3; i++) begin
      in_a = bp_a[i]; in_b = bp_b[i]; in_round = 1'b1; in_valid = 1'b1;
      @(negedge clk);
      if (in_ready) q.push_back(ref_result(bp_a[i], bp_b[i]));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("busy_before_rst", {32'd0, div_a}, {32'd0, bp_a[0]});
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    q.delete();
    @(negedge clk);
    chk("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("mid_rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("mid_rst_outputs", {28'd0, out_r, out_flags}, 64'd0);
    chk("mid_rst_div_ab", {div_a, div_b}, 64'd0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    repeat (20) @(posedge clk);
    #1 out_ready = 1'b0;
    @(posedge clk); #1;
    run_one("after_rst", 32'h40C00000, 32'h40000000, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
